// File: rtl/rd_frame_buf.sv
// Asymmetric simple dual-port line buffer: wide DDR write port, narrow registered read port, one clock.
// Define RD_OUT_REG_EN to add a second output register stage (read latency 2).
module rd_frame_buf #(
    parameter int unsigned WR_DATA_WIDTH = 128,
    parameter int unsigned WR_ADDR_WIDTH = 10,
    parameter int unsigned RD_DATA_WIDTH = 32,
    parameter int unsigned RD_ADDR_WIDTH = 12
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
    input  logic                     wr_en,
    input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned LANE_BITS  = RD_ADDR_WIDTH - WR_ADDR_WIDTH;
    localparam int unsigned LANE_SEL_W = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int unsigned RATIO      = 1 << LANE_BITS;
    localparam int unsigned DEPTH      = 1 << WR_ADDR_WIDTH;

    generate
        if ((longint'(WR_DATA_WIDTH) << WR_ADDR_WIDTH) != (longint'(RD_DATA_WIDTH) << RD_ADDR_WIDTH)) begin : g_bad_size
            $error("rd_frame_buf: write and read width*depth products differ");
        end
        if (WR_DATA_WIDTH != RD_DATA_WIDTH * RATIO) begin : g_bad_ratio
            $error("rd_frame_buf: WR_DATA_WIDTH must equal RD_DATA_WIDTH * 2**(RD_ADDR_WIDTH-WR_ADDR_WIDTH)");
        end
    endgenerate

    // Each row is stored as RATIO read lanes; lane 0 occupies the LSBs.
    logic [RATIO-1:0][RD_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [RD_DATA_WIDTH-1:0]            r_rd_data;
    logic [WR_ADDR_WIDTH-1:0]            w_row;
    logic [LANE_SEL_W-1:0]               w_lane;

    generate
        if (LANE_BITS > 0) begin : g_lane_split
            assign w_row  = rd_addr[RD_ADDR_WIDTH-1:LANE_BITS];
            assign w_lane = rd_addr[LANE_BITS-1:0];
        end else begin : g_lane_none
            assign w_row  = rd_addr;
            assign w_lane = '0;
        end
    endgenerate

    always_ff @(posedge wr_clk) begin
        if (!wr_rst && wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Reads the pre-write array contents, so a same-row write is read-first.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_row][w_lane];
        end
    end

`ifdef RD_OUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] r_out_data;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_out_data <= '0;
        end else begin
            r_out_data <= r_rd_data;
        end
    end

    assign rd_data = r_out_data;
`else
    assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_rd_frame_buf.sv
// Self-checking bench for rd_frame_buf: random data against an array model of the line buffer.
// Honours RD_OUT_REG_EN to select the expected read latency.
module tb_rd_frame_buf;

`ifdef RD_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         wr_clk = 1'b0;
    logic         wr_rst;
    logic [127:0] wr_data;
    logic [9:0]   wr_addr;
    logic         wr_en;
    logic [11:0]  rd_addr;
    logic [31:0]  rd_data;

    int checks   = 0;
    int failures = 0;

    logic [127:0] mem_m [0:1023];
    bit           known [0:1023];
    logic [31:0]  pipe_d [0:1];
    bit           pipe_v [0:1];
    logic [31:0]  exp_d;
    bit           exp_v;

    always #5 wr_clk = ~wr_clk;

    rd_frame_buf #(
        .WR_DATA_WIDTH(128),
        .WR_ADDR_WIDTH(10),
        .RD_DATA_WIDTH(32),
        .RD_ADDR_WIDTH(12)
    ) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .wr_data(wr_data),
        .wr_addr(wr_addr),
        .wr_en  (wr_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    function automatic logic [31:0] model_lane(input logic [11:0] a);
        logic [127:0] w;
        w = mem_m[a[11:2]];
        return w[32*a[1:0] +: 32];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock: model the read pipeline from the current inputs, then sample #1 after the edge.
    task automatic tick();
        logic [31:0] nd;
        bit          nv;
        nv = wr_rst || known[rd_addr[11:2]];
        nd = wr_rst ? 32'h0 : model_lane(rd_addr);
        if (wr_en && !wr_rst) begin
            mem_m[wr_addr] = wr_data;
            known[wr_addr] = 1'b1;
        end
        if (wr_rst) begin
            pipe_d[0] = '0; pipe_d[1] = '0;
            pipe_v[0] = 1'b1; pipe_v[1] = 1'b1;
        end else begin
            pipe_d[1] = pipe_d[0]; pipe_v[1] = pipe_v[0];
            pipe_d[0] = nd;        pipe_v[0] = nv;
        end
        @(posedge wr_clk);
        #1;
        exp_d = pipe_d[LAT-1];
        exp_v = pipe_v[LAT-1];
    endtask

    task automatic test_reset();
        wr_rst = 1'b1; wr_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_out cyc=%0d got=%h want=%h", i, rd_data, 32'h0);
            end
        end
        wr_rst = 1'b0;
    endtask

    task automatic test_lanes();
        logic [31:0] obs [0:5];
        wr_en = 1'b1; wr_addr = 10'd0;
        wr_data = 128'h44444444_33333333_22222222_11111111;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            rd_addr = (i < 4) ? 12'(i) : 12'd3;
            tick();
            obs[i] = rd_data;
            if (exp_v) begin
                checks++;
                if (rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL lanes_model cyc=%0d got=%h want=%h", i, rd_data, exp_d);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k+LAT-1] !== 32'h11111111 * 32'(k + 1)) begin
                failures++;
                $display("FAIL lanes_lit lane=%0d got=%h want=%h", k, obs[k+LAT-1], 32'h11111111 * 32'(k + 1));
            end
        end
    endtask

    task automatic test_wrap();
        logic [127:0] p;
        logic [127:0] q;
        logic [31:0]  obs [0:5];
        int           row;
        row = 1023;
        p = rand128();
        q = rand128();
        wr_en = 1'b1; wr_addr = 10'(row); wr_data = p;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            rd_addr = (i < 4) ? 12'(4092 + i) : 12'd4095;
            tick();
            obs[i] = rd_data;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k+LAT-1] !== p[32*k +: 32]) begin
                failures++;
                $display("FAIL wrap_top lane=%0d got=%h want=%h", k, obs[k+LAT-1], p[32*k +: 32]);
            end
        end
        // Row 1023+1 must land in row 0; read it back through a wrapped read address too.
        wr_en = 1'b1; wr_addr = 10'(row + 1); wr_data = q;
        tick();
        wr_en = 1'b0;
        rd_addr = 12'(4096 + 1);
        for (int i = 0; i < LAT; i++) tick();
        checks++;
        if (rd_data !== q[63:32]) begin
            failures++;
            $display("FAIL wrap_row0 got=%h want=%h", rd_data, q[63:32]);
        end
        checks++;
        if (rd_data !== exp_d) begin
            failures++;
            $display("FAIL wrap_model got=%h want=%h", rd_data, exp_d);
        end
    endtask

    task automatic test_read_during_write();
        logic [127:0] x;
        logic [127:0] y;
        logic [31:0]  obs [0:3];
        x = rand128();
        y = rand128();
        while (y[31:0] == x[31:0]) y = rand128();
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = x; rd_addr = 12'd0;
        tick();
        wr_data = y; rd_addr = 12'd20;
        tick();
        obs[0] = rd_data;
        wr_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            obs[i] = rd_data;
            checks++;
            if (rd_data !== exp_d) begin
                failures++;
                $display("FAIL rdw_model cyc=%0d got=%h want=%h", i, rd_data, exp_d);
            end
        end
        checks++;
        if (obs[LAT-1] !== x[31:0]) begin
            failures++;
            $display("FAIL rdw_old got=%h want=%h", obs[LAT-1], x[31:0]);
        end
        checks++;
        if (obs[LAT] !== y[31:0]) begin
            failures++;
            $display("FAIL rdw_new got=%h want=%h", obs[LAT], y[31:0]);
        end
    endtask

    task automatic test_reset_hold();
        logic [127:0] d;
        logic [31:0]  obs [0:3];
        d = rand128();
        wr_en = 1'b1; wr_addr = 10'd7; wr_data = d; rd_addr = 12'd28;
        tick();
        wr_rst = 1'b1; wr_data = ~d;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_data !== 32'h0) begin
                failures++;
                $display("FAIL rsthold_zero cyc=%0d got=%h want=%h", i, rd_data, 32'h0);
            end
        end
        wr_rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs[i] = rd_data;
            checks++;
            if (rd_data !== exp_d) begin
                failures++;
                $display("FAIL rsthold_model cyc=%0d got=%h want=%h", i, rd_data, exp_d);
            end
        end
        checks++;
        if (obs[LAT-1] !== d[31:0]) begin
            failures++;
            $display("FAIL rsthold_keep got=%h want=%h", obs[LAT-1], d[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        rd_addr = 12'd0;
        wr_en = 1'b1;
        for (int r = 0; r < 180; r++) begin
            wr_addr = 10'(r);
            wr_data = rand128();
            tick();
        end
        wr_en = 1'b0;
        for (int a = 0; a < 720 + LAT; a++) begin
            rd_addr = (a < 720) ? 12'(a) : 12'd719;
            tick();
            if (exp_v) begin
                checks++;
                if (rd_data !== exp_d) begin
                    failures++;
                    errs++;
                    if (errs <= 8) $display("FAIL stream cyc=%0d got=%h want=%h", a, rd_data, exp_d);
                end
            end
        end
    endtask

    task automatic test_stable();
        logic [31:0] first;
        rd_addr = 12'd13; wr_en = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        first = rd_data;
        checks++;
        if (first !== exp_d) begin
            failures++;
            $display("FAIL stable_model got=%h want=%h", first, exp_d);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rd_data !== first) begin
                failures++;
                $display("FAIL stable_hold cyc=%0d got=%h want=%h", i, rd_data, first);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_m[i] = '0;
            known[i] = 1'b0;
        end
        pipe_d[0] = '0; pipe_d[1] = '0;
        pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
        exp_d = '0; exp_v = 1'b0;
        test_reset();
        test_lanes();
        test_wrap();
        test_read_during_write();
        test_reset_hold();
        test_back_to_back();
        test_stable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
